// File: rtl/dff_write_arbiter.sv
// Round-robin arbiter granting three requesters write access to one shared
// register, at most one write every two cycles.
module dff_write_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [WIDTH-1:0] preset,
   input  logic [2:0]       req,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   output logic [2:0]       gnt,
   output logic             ce,
   output logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } state_t;

   state_t           state_q;
   logic [1:0]       ptr_q;
   logic [1:0]       win_q;
   logic [1:0]       pick;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] win_data;
   logic             wr_en;

   // Search starts one past the last completed writer.
   always_comb begin
      pick = 2'd0;
      unique case (ptr_q)
         2'd0: begin
            if (req[1])      pick = 2'd1;
            else if (req[2]) pick = 2'd2;
            else             pick = 2'd0;
         end
         2'd1: begin
            if (req[2])      pick = 2'd2;
            else if (req[0]) pick = 2'd0;
            else             pick = 2'd1;
         end
         default: begin
            if (req[0])      pick = 2'd0;
            else if (req[1]) pick = 2'd1;
            else             pick = 2'd2;
         end
      endcase
   end

   always_comb begin
      win_data = d2;
      unique case (win_q)
         2'd0:    win_data = d0;
         2'd1:    win_data = d1;
         default: win_data = d2;
      endcase
   end

   assign wr_en = (state_q == WRITE) && !clr && !rst;
   assign ce    = wr_en;
   assign gnt   = wr_en ? (3'b001 << win_q) : 3'b000;
   assign d     = wr_en ? win_data : '0;
   assign busy  = (state_q == WRITE) && !rst;
   assign q     = q_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= 2'd2;
         win_q   <= 2'd0;
         q_q     <= preset;
      end else if (clr) begin
         state_q <= IDLE;
         q_q     <= preset;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (|req) begin
                  win_q   <= pick;
                  state_q <= WRITE;
               end
            end
            WRITE: begin
               q_q     <= win_data;
               ptr_q   <= win_q;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
